// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//
// Host-to-device PS/2 transmitter. Sends one command byte (for example 0xF4
// "enable data reporting" or 0xFF "reset") to a PS/2 mouse over the shared
// open-drain PS2_CLK / PS2_DAT lines, then waits for the device ACK.
//
// Frame sequence:
//   IDLE -> INHIBIT (CLK held low) -> START (DAT low, CLK still low)
//        -> TX (8 data bits LSB first, odd parity, stop)
//        -> ACK (sample device ACK on falling edge 11)
//        -> WAIT_IDLE (both lines high) -> IDLE with an oDone pulse.
//   Timeout or NACK -> FAIL -> IDLE with an oError pulse.
//
// Ports:
//   CLOCK_50  in    system clock (50 MHz)
//   reset     in    synchronous, active-high reset
//   iCommand  in    [7:0] command byte, captured when iSend is accepted
//   iSend     in    single-cycle start request (ignored while busy)
//   oBusy     out   high from the cycle after acceptance until done/error
//   oDone     out   one-cycle pulse: device acknowledged the frame
//   oError    out   one-cycle pulse: timeout or NACK
//   PS2_CLK   inout open-drain clock, driven 0 or Z only
//   PS2_DAT   inout open-drain data,  driven 0 or Z only
//
// Parameters:
//   INHIBIT_CYCLES  cycles PS2_CLK is held low before the request
//   TIMEOUT_CYCLES  longest wait for any expected device clock edge
//   MAX_RETRIES     extra attempts after a failed frame (retry build only)
//
// Build option:
//   PS2_TX_RETRY_EN  when defined, a NACK or timeout releases the lines for
//                    one cycle and restarts from INHIBIT with the same byte,
//                    up to MAX_RETRIES extra times; oError only pulses after
//                    the last attempt fails and oBusy stays high throughout.
//                    When undefined, the first failure reports oError.
// ---------------------------------------------------------------------------
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000,
   parameter int MAX_RETRIES    = 2
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [7:0] iCommand,
   input  logic       iSend,
   output logic       oBusy,
   output logic       oDone,
   output logic       oError,
   inout  wire        PS2_CLK,
   inout  wire        PS2_DAT
);

`ifdef PS2_TX_RETRY_EN
   localparam logic RETRY_EN = 1'b1;
`else
   localparam logic RETRY_EN = 1'b0;
`endif

   // One counter serves both the inhibit delay and the watchdog, so it is
   // sized for whichever limit is larger.
   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                              : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_START,
      S_TX,
      S_ACK,
      S_WAIT_IDLE,
      S_FAIL,
      S_RETRY
   } state_t;

   state_t          state_q;
   logic [7:0]      cmd_q;
   logic            par_q;
   logic [3:0]      bit_q;
   logic [CW-1:0]   cnt_q;
   logic [3:0]      retry_q;
   logic            clk_oe_q;
   logic            dat_oe_q;
   logic            busy_q;
   logic            done_q;
   logic            err_q;

   logic            clk_s1_q;
   logic            clk_s2_q;
   logic            clk_s3_q;
   logic            dat_s1_q;
   logic            dat_s2_q;

   logic            clk_fall;
   logic [3:0]      bit_d;
   logic            wd_expired;
   state_t          fail_state_d;

   // ------------------------------------------------------------------------
   // Pin synchronizers. clk_s2_q/dat_s2_q are the synchronized "current"
   // values; clk_s3_q is the previous synchronized clock used for edge
   // detection. They reset to 1 (bus idle) so no false edge follows reset.
   // ------------------------------------------------------------------------
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         clk_s3_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
      end else begin
         clk_s1_q <= PS2_CLK;
         clk_s2_q <= clk_s1_q;
         clk_s3_q <= clk_s2_q;
         dat_s1_q <= PS2_DAT;
         dat_s2_q <= dat_s1_q;
      end
   end

   always_comb begin
      clk_fall     = clk_s3_q & ~clk_s2_q;
      // Saturating falling-edge count: stray edges can never wrap it.
      bit_d        = (bit_q == 4'hF) ? bit_q : bit_q + 4'd1;
      wd_expired   = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
      // Where a failed attempt goes: another try while retries remain
      // (retry build only), otherwise report the error.
      fail_state_d = S_FAIL;
      if (RETRY_EN && (int'(retry_q) < MAX_RETRIES)) begin
         fail_state_d = S_RETRY;
      end
   end

   // ------------------------------------------------------------------------
   // Transmit FSM. All outputs, including the open-drain enables, are
   // registered here. oe=1 pulls the line low; oe=0 releases it to Z.
   // ------------------------------------------------------------------------
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q  <= S_IDLE;
         bit_q    <= 4'd0;
         cnt_q    <= '0;
         retry_q  <= 4'd0;
         clk_oe_q <= 1'b0;
         dat_oe_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;

         case (state_q)
            S_IDLE: begin
               clk_oe_q <= 1'b0;
               dat_oe_q <= 1'b0;
               if (iSend) begin
                  cmd_q    <= iCommand;
                  par_q    <= ~^iCommand;
                  retry_q  <= 4'd0;
                  bit_q    <= 4'd0;
                  cnt_q    <= '0;
                  clk_oe_q <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= S_INHIBIT;
               end
            end

            // CLK has been low since the acceptance edge; after exactly
            // INHIBIT_CYCLES cycles the start bit is placed on DAT.
            S_INHIBIT: begin
               if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                  dat_oe_q <= 1'b1;
                  cnt_q    <= '0;
                  state_q  <= S_START;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end

            // DAT has been low for one cycle with CLK still low: releasing
            // CLK now is the request-to-send the device responds to.
            S_START: begin
               clk_oe_q <= 1'b0;
               bit_q    <= 4'd0;
               cnt_q    <= '0;
               state_q  <= S_TX;
            end

            // Device-clocked shift-out. Each change lands while the device
            // holds CLK low; it samples on the following rising edge.
            S_TX: begin
               if (clk_fall) begin
                  cnt_q <= '0;
                  bit_q <= bit_d;
                  if (bit_d <= 4'd8) begin
                     // Edge n drives data bit n-1, which is bit_q here.
                     dat_oe_q <= ~cmd_q[bit_q[2:0]];
                  end else if (bit_d == 4'd9) begin
                     dat_oe_q <= ~par_q;
                  end else begin
                     dat_oe_q <= 1'b0;
                     state_q  <= S_ACK;
                  end
               end else if (wd_expired) begin
                  clk_oe_q <= 1'b0;
                  dat_oe_q <= 1'b0;
                  state_q  <= fail_state_d;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end

            // Falling edge 11: the device pulls DAT low to acknowledge.
            S_ACK: begin
               if (clk_fall) begin
                  cnt_q <= '0;
                  bit_q <= bit_d;
                  if (!dat_s2_q) begin
                     state_q <= S_WAIT_IDLE;
                  end else begin
                     clk_oe_q <= 1'b0;
                     dat_oe_q <= 1'b0;
                     state_q  <= fail_state_d;
                  end
               end else if (wd_expired) begin
                  clk_oe_q <= 1'b0;
                  dat_oe_q <= 1'b0;
                  state_q  <= fail_state_d;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end

            // Frame is complete once the device has released both lines.
            // Further clock edges only restart the watchdog.
            S_WAIT_IDLE: begin
               if (clk_s2_q && dat_s2_q) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (clk_fall) begin
                  cnt_q <= '0;
                  bit_q <= bit_d;
               end else if (wd_expired) begin
                  clk_oe_q <= 1'b0;
                  dat_oe_q <= 1'b0;
                  state_q  <= fail_state_d;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end

            S_FAIL: begin
               clk_oe_q <= 1'b0;
               dat_oe_q <= 1'b0;
               err_q    <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= S_IDLE;
            end

            // Lines were released on entry; restart the inhibit with the
            // byte and parity already latched.
            S_RETRY: begin
               retry_q  <= retry_q + 4'd1;
               bit_q    <= 4'd0;
               cnt_q    <= '0;
               clk_oe_q <= 1'b1;
               state_q  <= S_INHIBIT;
            end

            default: begin
               clk_oe_q <= 1'b0;
               dat_oe_q <= 1'b0;
               state_q  <= S_IDLE;
            end
         endcase
      end
   end

   assign PS2_CLK = clk_oe_q ? 1'b0 : 1'bz;
   assign PS2_DAT = dat_oe_q ? 1'b0 : 1'bz;

   assign oBusy  = busy_q;
   assign oDone  = done_q;
   assign oError = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

   localparam int INH  = 50;
   localparam int TMO  = 2000;
   localparam int RETR = 2;
   localparam int H    = 8;     // mouse half-period in system cycles

   typedef struct packed {
      logic [7:0] cmd;
      logic       par;
      logic       ack;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] cmd = 8'h00;
   logic       snd = 1'b0;
   logic       busy, done, err;
   logic       m_clk_lo = 1'b0;
   logic       m_dat_lo = 1'b0;
   wire        ps2_clk;
   wire        ps2_dat;

   pullup (ps2_clk);
   pullup (ps2_dat);
   assign ps2_clk = m_clk_lo ? 1'b0 : 1'bz;
   assign ps2_dat = m_dat_lo ? 1'b0 : 1'bz;

   always #10 clk = ~clk;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TMO),
      .MAX_RETRIES   (RETR)
   ) dut (
      .CLOCK_50(clk),
      .reset   (rst),
      .iCommand(cmd),
      .iSend   (snd),
      .oBusy   (busy),
      .oDone   (done),
      .oError  (err),
      .PS2_CLK (ps2_clk),
      .PS2_DAT (ps2_dat)
   );

   exp_t sb[$];
   int   n_chk = 0;
   int   n_pass = 0;

   // Bus activity monitor
   int   done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_cnt = 0, busy_fall = 0;
   logic clk_prev = 1'b1, busy_prev = 1'b0;

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt <= done_cnt + 1;
      if (err === 1'b1) err_cnt <= err_cnt + 1;
      if (done === 1'b1 && err === 1'b1) both_cnt <= both_cnt + 1;
      if (clk_prev === 1'b1 && ps2_clk === 1'b0 && !m_clk_lo) inh_cnt <= inh_cnt + 1;
      if (busy_prev === 1'b1 && busy === 1'b0) busy_fall <= busy_fall + 1;
      clk_prev  <= ps2_clk;
      busy_prev <= busy;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] c, input logic ack);
      exp_t e;
      @(negedge clk);
      cmd = c;
      snd = 1'b1;
      @(negedge clk);
      snd = 1'b0;
      e.cmd = c;
      e.par = ($countones(c) % 2 == 0);
      e.ack = ack;
      sb.push_back(e);
      check_eq("busy_after_accept", busy, 1);
   endtask

   // Bus-functional mouse: receives one host frame and answers ACK/NACK.
   task automatic mouse_rx(input logic ack, output logic [7:0] d, output logic p,
                           output logic s, output logic st, output int inh, output bit ok);
      int   t;
      logic b;
      ok = 1'b0; d = 8'h00; p = 1'b0; s = 1'b0; st = 1'b1; inh = 0;
      t = 0;
      while (ps2_clk !== 1'b0 && t < 4 * INH) begin @(negedge clk); t++; end
      if (ps2_clk !== 1'b0) return;
      while (ps2_clk === 1'b0 && ps2_dat === 1'b1 && inh < 4 * INH) begin
         @(negedge clk);
         inh++;
      end
      st = ps2_dat;
      t = 0;
      while (ps2_clk !== 1'b1 && t < 20) begin @(negedge clk); t++; end
      if (ps2_clk !== 1'b1) return;
      cyc(4);
      for (int i = 1; i <= 10; i++) begin
         m_clk_lo = 1'b1;
         cyc(H);
         b = ps2_dat;
         m_clk_lo = 1'b0;
         cyc(H);
         if (i <= 8) d[i-1] = b;
         else if (i == 9) p = b;
         else s = b;
      end
      if (ack) m_dat_lo = 1'b1;
      cyc(H / 2);
      m_clk_lo = 1'b1;
      cyc(2);
      m_clk_lo = 1'b0;
      if (ack) begin
         cyc(4);
         m_dat_lo = 1'b0;
      end else begin
         cyc(1);
      end
      ok = 1'b1;
   endtask

   task automatic wait_idle(input int budget);
      int t;
      t = 0;
      while (busy !== 1'b0 && t < budget) begin @(negedge clk); t++; end
      if (busy !== 1'b0) check_eq("busy_drop_timeout", busy, 0);
      cyc(3);
   endtask

   task automatic run_frame(input logic [7:0] c, input logic ack, input bit poke);
      logic [7:0] d;
      logic       p, s, st;
      int         inh, d0, e0, i0;
      bit         ok;
      exp_t       e;
      d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
      send(c, ack);
      fork
         mouse_rx(ack, d, p, s, st, inh, ok);
         if (poke) begin
            cyc(INH + 60);
            cmd = 8'h55;
            snd = 1'b1;
            cyc(1);
            snd = 1'b0;
            cmd = 8'h00;
         end
      join
      wait_idle(500);
      e = sb.pop_front();
      check_eq("mouse_sync", ok, 1);
      check_eq("inhibit_len", inh, INH);
      check_eq("start_bit", st, 0);
      check_eq("data_byte", d, e.cmd);
      check_eq("parity_bit", p, e.par);
      check_eq("stop_bit", s, 1);
      check_eq("done_pulses", done_cnt - d0, e.ack ? 1 : 0);
      check_eq("error_pulses", err_cnt - e0, e.ack ? 0 : 1);
      check_eq("busy_end", busy, 0);
      check_eq("lines_released", {ps2_clk, ps2_dat}, 2'b11);
      if (poke) cyc(100);
      check_eq("inhibit_phases", inh_cnt - i0, 1);
   endtask

   initial begin
      #1_600_000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "global timeout");
   end

   initial begin
      logic [7:0] d;
      logic       p, s, st;
      int         inh, d0, e0, i0, b0, t;
      bit         ok;
      exp_t       e;

      // Reset state
      rst = 1'b1;
      cyc(3);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_error", err, 0);
      check_eq("rst_clk_z", ps2_clk, 1);
      check_eq("rst_dat_z", ps2_dat, 1);
      rst = 1'b0;
      cyc(2);

      // ACKed frames with distinct bit/parity patterns
      run_frame(8'hF4, 1'b1, 1'b0);
      run_frame(8'hFF, 1'b1, 1'b0);
      run_frame(8'h00, 1'b1, 1'b0);
      run_frame(8'h5A, 1'b1, 1'b0);

`ifdef PS2_TX_RETRY_EN
      // NACK, NACK, ACK with retries
      d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt; b0 = busy_fall;
      send(8'hF4, 1'b1);
      for (int a = 0; a < 3; a++) begin
         mouse_rx(a == 2, d, p, s, st, inh, ok);
         check_eq("retry_sync", ok, 1);
         check_eq("retry_inhibit_len", inh, INH);
         check_eq("retry_data", d, sb[0].cmd);
         check_eq("retry_parity", p, sb[0].par);
      end
      wait_idle(500);
      e = sb.pop_front();
      check_eq("retry_inhibit_phases", inh_cnt - i0, 3);
      check_eq("retry_done", done_cnt - d0, 1);
      check_eq("retry_error", err_cnt - e0, 0);
      check_eq("retry_busy_falls", busy_fall - b0, 1);
`else
      // Single NACK reports an error
      run_frame(8'hF4, 1'b0, 1'b0);
`endif

      // Device never clocks: watchdog
      d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
      send(8'hF4, 1'b0);
      t = 0;
      while (ps2_clk !== 1'b1 && t < 4 * INH) begin @(negedge clk); t++; end
      check_eq("timeout_clk_release", ps2_clk, 1);
`ifdef PS2_TX_RETRY_EN
      t = 0;
      while (err !== 1'b1 && t < 4 * (INH + TMO)) begin @(negedge clk); t++; end
      check_eq("timeout_error_seen", err, 1);
      cyc(3);
      check_eq("timeout_inhibit_phases", inh_cnt - i0, 3);
`else
      t = 0;
      while (err !== 1'b1 && t < TMO + 10) begin @(negedge clk); t++; end
      check_eq("timeout_window", (t >= TMO && t <= TMO + 3), 1);
      cyc(3);
`endif
      e = sb.pop_front();
      check_eq("timeout_error_pulses", err_cnt - e0, e.ack ? 0 : 1);
      check_eq("timeout_done_pulses", done_cnt - d0, 0);
      check_eq("timeout_busy", busy, 0);
      check_eq("timeout_lines_z", {ps2_clk, ps2_dat}, 2'b11);

      // iSend while busy is ignored
      run_frame(8'hF4, 1'b1, 1'b1);

      // Reset during bit 4
      d0 = done_cnt; e0 = err_cnt;
      @(negedge clk);
      cmd = 8'hF4;
      snd = 1'b1;
      @(negedge clk);
      snd = 1'b0;
      t = 0;
      while (ps2_clk !== 1'b0 && t < 10) begin @(negedge clk); t++; end
      t = 0;
      while (ps2_clk !== 1'b1 && t < 4 * INH) begin @(negedge clk); t++; end
      cyc(4);
      for (int i = 0; i < 3; i++) begin
         m_clk_lo = 1'b1; cyc(H);
         m_clk_lo = 1'b0; cyc(H);
      end
      m_clk_lo = 1'b1;
      cyc(H);
      check_eq("bit3_driven_low", ps2_dat, 0);
      rst = 1'b1;
      @(negedge clk);
      check_eq("reset_dat_z", ps2_dat, 1);
      check_eq("reset_busy", busy, 0);
      m_clk_lo = 1'b0;
      cyc(1);
      check_eq("reset_clk_z", ps2_clk, 1);
      rst = 1'b0;
      cyc(50);
      check_eq("reset_no_done", done_cnt - d0, 0);
      check_eq("reset_no_error", err_cnt - e0, 0);

      // Clean frame after reset
      run_frame(8'hF4, 1'b1, 1'b0);

      check_eq("done_error_overlap", both_cnt, 0);
      check_eq("scoreboard_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
